// File: rtl/ball_pkg.sv
// ball_pkg: cell codes, FSM states and default map geometry for the ball collision checker.
package ball_pkg;
    localparam logic [1:0] CELL_OPEN0 = 2'd0;
    localparam logic [1:0] CELL_OPEN1 = 2'd1;
    localparam logic [1:0] CELL_WALL  = 2'd2;
    localparam logic [1:0] CELL_GOAL  = 2'd3;
    localparam int unsigned DEFAULT_MAP_W = 16;
    localparam int unsigned DEFAULT_MAP_H = 16;
    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;
endpackage

// File: rtl/ball_collision_check.sv
// ball_collision_check: commits a proposed ball move unless the target map cell is a wall; flags the goal.
module ball_collision_check
    import ball_pkg::*;
#(
    parameter int unsigned MAP_W          = DEFAULT_MAP_W,
    parameter int unsigned MAP_H          = DEFAULT_MAP_H,
    parameter int unsigned COORD_WIDTH    = 8,
    parameter int unsigned MAP_ADDR_WIDTH = 8,
    parameter int unsigned ROM_LATENCY    = 1,
    parameter int unsigned START_X        = 0,
    parameter int unsigned START_Y        = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [COORD_WIDTH-1:0]    req_x,
    input  logic [COORD_WIDTH-1:0]    req_y,
    output logic                      map_rd,
    output logic [MAP_ADDR_WIDTH-1:0] map_addr,
    input  logic [1:0]                map_data,
    output logic [COORD_WIDTH-1:0]    x_out,
    output logic [COORD_WIDTH-1:0]    y_out,
    output logic                      move_ok,
    output logic                      move_blocked,
    output logic                      goal_reached
);
    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [COORD_WIDTH-1:0]    x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
    logic                      map_rd_q, map_rd_d;
    logic [MAP_ADDR_WIDTH-1:0] map_addr_q, map_addr_d;
    logic                      ok_q, ok_d, blocked_q, blocked_d, goal_q, goal_d;
    logic                      accept, same_pos, in_range;
    logic [31:0]               addr_full;

    assign req_ready    = state_q == IDLE && !goal_q;
    assign map_rd       = map_rd_q;
    assign map_addr     = map_addr_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign move_ok      = ok_q;
    assign move_blocked = blocked_q;
    assign goal_reached = goal_q;

    always_comb begin
        accept     = req_valid && req_ready;
        same_pos   = req_x == x_q && req_y == y_q;
        in_range   = 32'(req_x) < MAP_W && 32'(req_y) < MAP_H;
        addr_full  = 32'(req_y) * MAP_W + 32'(req_x);
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        map_rd_d   = 1'b0;
        map_addr_d = map_addr_q;
        ok_d       = 1'b0;
        blocked_d  = 1'b0;
        goal_d     = goal_q;
        case (state_q)
            IDLE: if (accept && !same_pos) begin
                if (!in_range) blocked_d = 1'b1;
                else begin
                    state_d    = READ;
                    cx_d       = req_x;
                    cy_d       = req_y;
                    map_rd_d   = 1'b1;
                    map_addr_d = MAP_ADDR_WIDTH'(addr_full);
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = 2'(ROM_LATENCY - 1);
            end
            WAIT: if (cnt_q == 2'd0) begin
                state_d = IDLE;
                if (map_data == CELL_WALL) blocked_d = 1'b1;
                else begin
                    x_d    = cx_q;
                    y_d    = cy_q;
                    ok_d   = 1'b1;
                    goal_d = goal_q || map_data == CELL_GOAL;
                end
            end else cnt_d = cnt_q - 2'd1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            x_q        <= COORD_WIDTH'(START_X);
            y_q        <= COORD_WIDTH'(START_Y);
            cx_q       <= '0;
            cy_q       <= '0;
            map_rd_q   <= 1'b0;
            map_addr_q <= '0;
            ok_q       <= 1'b0;
            blocked_q  <= 1'b0;
            goal_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            map_rd_q   <= map_rd_d;
            map_addr_q <= map_addr_d;
            ok_q       <= ok_d;
            blocked_q  <= blocked_d;
            goal_q     <= goal_d;
        end
    end
endmodule

// File: tb/tb_ball_collision_check.sv
// tb_ball_collision_check: directed checks of two instances (ROM latency 1 and 3) sharing one stimulus.
module tb_ball_collision_check;
    logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic [7:0] req_x = '0, req_y = '0;
    logic       rdy1, rd1, ok1, blk1, goal1, rdy3, rd3, ok3, blk3, goal3;
    logic [7:0] addr1, addr3, x1, y1, x3, y3;
    logic [1:0] data1, data3;
    logic [1:0] mem [256];
    logic [7:0] p1;
    logic [7:0] p3 [3];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    ball_collision_check dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_x(req_x), .req_y(req_y),
        .map_rd(rd1), .map_addr(addr1), .map_data(data1), .x_out(x1), .y_out(y1),
        .move_ok(ok1), .move_blocked(blk1), .goal_reached(goal1));

    ball_collision_check #(.ROM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3), .req_x(req_x), .req_y(req_y),
        .map_rd(rd3), .map_addr(addr3), .map_data(data3), .x_out(x3), .y_out(y3),
        .move_ok(ok3), .move_blocked(blk3), .goal_reached(goal3));

    always @(posedge clk) begin
        p1    <= addr1;
        p3[0] <= addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign data1 = mem[p1];
    assign data3 = mem[p3[2]];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        req_x = 8'hAA;
        req_y = 8'h55;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++; if (x1 !== 8'd0 || y1 !== 8'd0) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", x1, y1); end
        checks++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", rdy1, rdy3); end
        checks++; if ({ok1, blk1, goal1, rd1} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {ok1, blk1, goal1, rd1}); end
        checks++; if (addr1 !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr1); end
    endtask

    task automatic test_move_ok;
        send(8'd1, 8'd0);
        checks++; if (rd1 !== 1'b1 || addr1 !== 8'd1) begin errors++; $display("FAIL ok_read: got rd=%b addr=%0d expected rd=1 addr=1", rd1, addr1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL ok_busy: got ready=%b expected 0", rdy1); end
        step(1);
        checks++; if (ok1 !== 1'b0 || x1 !== 8'd0) begin errors++; $display("FAIL ok_early: got ok=%b x=%0d expected ok=0 x=0", ok1, x1); end
        step(1);
        checks++; if (ok1 !== 1'b1 || blk1 !== 1'b0 || x1 !== 8'd1 || y1 !== 8'd0) begin errors++; $display("FAIL ok_commit: got ok=%b blk=%b pos=(%0d,%0d) expected ok=1 blk=0 (1,0)", ok1, blk1, x1, y1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ok_ready: got %b expected 1", rdy1); end
        step(1);
        checks++; if (ok1 !== 1'b0) begin errors++; $display("FAIL ok_width: got ok=%b expected 0", ok1); end
        step(1);
        checks++; if (ok3 !== 1'b1 || x3 !== 8'd1) begin errors++; $display("FAIL ok_lat3: got ok=%b x=%0d expected ok=1 x=1", ok3, x3); end
        step(2);
    endtask

    task automatic test_wall;
        send(8'd2, 8'd0);
        checks++; if (rd1 !== 1'b1 || addr1 !== 8'd2) begin errors++; $display("FAIL wall_read: got rd=%b addr=%0d expected rd=1 addr=2", rd1, addr1); end
        step(2);
        checks++; if (blk1 !== 1'b1 || ok1 !== 1'b0) begin errors++; $display("FAIL wall_pulse: got blk=%b ok=%b expected blk=1 ok=0", blk1, ok1); end
        checks++; if (x1 !== 8'd1 || y1 !== 8'd0) begin errors++; $display("FAIL wall_pos: got (%0d,%0d) expected (1,0)", x1, y1); end
        step(1);
        checks++; if (blk1 !== 1'b0) begin errors++; $display("FAIL wall_width: got blk=%b expected 0", blk1); end
        step(3);
    endtask

    task automatic test_out_of_range;
        send(8'd16, 8'd3);
        checks++; if (blk1 !== 1'b1 || blk3 !== 1'b1) begin errors++; $display("FAIL oor_pulse: got %b/%b expected 1/1", blk1, blk3); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", rdy1); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd1 !== 1'b0 || rd3 !== 1'b0) begin errors++; $display("FAIL oor_no_read: cycle %0d got rd=%b/%b expected 0/0", i, rd1, rd3); end
            step(1);
        end
        checks++; if (blk1 !== 1'b0 || x1 !== 8'd1) begin errors++; $display("FAIL oor_after: got blk=%b x=%0d expected blk=0 x=1", blk1, x1); end
    endtask

    task automatic test_same_pos;
        send(8'd1, 8'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({rd1, ok1, blk1, rd3, ok3, blk3} !== 6'b0) begin errors++; $display("FAIL same_quiet: cycle %0d got %b expected 000000", i, {rd1, ok1, blk1, rd3, ok3, blk3}); end
            checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL same_ready: cycle %0d got %b expected 1", i, rdy1); end
            step(1);
        end
    endtask

    task automatic test_reset_mid;
        send(8'd3, 8'd0);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b/%b expected 1/1", rdy1, rdy3); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (ok1 !== 1'b0 || ok3 !== 1'b0 || x1 !== 8'd0 || x3 !== 8'd0) begin errors++; $display("FAIL rmid_abort: cycle %0d got ok=%b/%b x=%0d/%0d expected 0/0 0/0", i, ok1, ok3, x1, x3); end
            step(1);
        end
    endtask

    task automatic test_goal;
        send(8'd5, 8'd4);
        checks++; if (rd3 !== 1'b1 || addr3 !== 8'd69) begin errors++; $display("FAIL goal_read: got rd=%b addr=%0d expected rd=1 addr=69", rd3, addr3); end
        step(3);
        checks++; if (ok3 !== 1'b0 || goal3 !== 1'b0) begin errors++; $display("FAIL goal_early: got ok=%b goal=%b expected 0/0", ok3, goal3); end
        step(1);
        checks++; if (ok3 !== 1'b1 || x3 !== 8'd5 || y3 !== 8'd4 || goal3 !== 1'b1) begin errors++; $display("FAIL goal_commit: got ok=%b pos=(%0d,%0d) goal=%b expected ok=1 (5,4) goal=1", ok3, x3, y3, goal3); end
        checks++; if (goal1 !== 1'b1 || x1 !== 8'd5) begin errors++; $display("FAIL goal_lat1: got goal=%b x=%0d expected goal=1 x=5", goal1, x1); end
        req_x = 8'd6;
        req_y = 8'd4;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++; if (rdy1 !== 1'b0 || rdy3 !== 1'b0 || rd1 !== 1'b0 || rd3 !== 1'b0 || x3 !== 8'd5) begin errors++; $display("FAIL goal_frozen: cycle %0d got ready=%b/%b rd=%b/%b x=%0d expected 0/0 0/0 5", i, rdy1, rdy3, rd1, rd3, x3); end
        end
        req_valid = 1'b0;
        checks++; if (goal1 !== 1'b1 || goal3 !== 1'b1) begin errors++; $display("FAIL goal_sticky: got %b/%b expected 1/1", goal1, goal3); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'd0;
        mem[2]  = 2'd2;
        mem[69] = 2'd3;
        mem[3]  = 2'd1;
        #1;
        test_reset;
        test_move_ok;
        test_wall;
        test_out_of_range;
        test_same_pos;
        test_reset_mid;
        test_goal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
